spell_mem_arbiter: RTL
======================

# spell_mem_arbiter

Two-port arbiter that shares the single spell memory/IO port between the CPU core (port 0) and the debug/loader engine (port 1). It sits between the requesters and the memory block. It grants one transaction at a time using round-robin, and forces a one-cycle idle gap on the memory select between transactions. A watchdog terminates any transaction the memory never completes, so the CPU FSM cannot hang.

## Interface
Parameters:
- TIMEOUT_W, 8: width of the watchdog counter.
- TIMEOUT, 200: number of cycles in GRANT without `mem_data_ready` before the transaction is aborted. Legal range is 1 to 2^TIMEOUT_W−1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rN_select  in  1  request from port N (N=0,1). Level signal, held until `rN_data_ready`.
- rN_addr  in  8  transaction address. Must be stable while `rN_select` is high.
- rN_data_in  in  8  write data.
- rN_type_data  in  1  1 = data memory, 0 = code memory.
- rN_write  in  1  1 = write, 0 = read.
- rN_data_ready  out  1  one-cycle completion pulse to port N.
- rN_data_out  out  8  read data, valid only while `rN_data_ready` is high.
- mem_select, mem_addr[7:0], mem_data_in[7:0], mem_type_data, mem_write  out  forwarded to the memory block.
- mem_data_out  in  8  memory read data.
- mem_data_ready  in  1  memory completion pulse.
- grant  out  2  one-hot: current owner. 00 when no port owns the memory.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted.
- timeout_cnt  out  8  saturating count of aborts since reset.

## Operation
- States: IDLE, GRANT, GAP.
- Registers: `state`, `owner` (1 bit), `last` (1 bit, last port served), `wd` (TIMEOUT_W bits), `timeout_cnt`.
- IDLE:
  - If exactly one `rN_select` is high, that port becomes `owner` and the FSM moves to GRANT.
  - If both are high, `owner = ~last` (round-robin). After reset `last = 1`, so port 0 wins the first tie.
  - `wd` is cleared on entry to GRANT.
- GRANT:
  - `mem_select = r[owner]_select`.
  - `mem_addr`, `mem_data_in`, `mem_type_data` and `mem_write` are a combinational mux of the owner's inputs.
  - The non-owner's `select` is ignored, and that port sees `data_ready = 0`.
- Completion: `mem_data_ready` is high in GRANT.
  - `r[owner]_data_ready` is driven high in the same cycle (combinational pass-through).
  - `r[owner]_data_out = mem_data_out`.
  - `last <= owner`; next state is GAP.
- Abort by requester: `r[owner]_select` drops in GRANT before ready. Next state is GAP and no ready pulse is issued.
- Watchdog: `wd` increments every GRANT cycle without ready.
  - When `wd == TIMEOUT−1` and ready is still low, the arbiter issues `r[owner]_data_ready = 1` with `r[owner]_data_out = 8'hFF`.
  - In the same cycle it pulses `timeout_err`, increments `timeout_cnt` (saturating at 255), sets `last <= owner`, and moves to GAP.
- If `mem_data_ready` and the watchdog expiry coincide, the real completion wins: memory data is passed through and no error is flagged.
- GAP:
  - All `mem_*` outputs are 0 and `grant = 00`.
  - The state returns to IDLE unconditionally after one cycle.
  - Requesters drop select on the cycle after their ready pulse. A select still high in IDLE is treated as a new request.
- `mem_data_ready` arriving in IDLE or GAP is ignored: no pulse goes to either port.
- `grant` equals `1 << owner` in GRANT and is 00 otherwise. `busy` is `state != IDLE`.

## Timing
- Reset (`rst_n` low at a clk edge):
  - State goes to IDLE; `last = 1`, `wd = 0`, `timeout_cnt = 0`.
  - All outputs read 0: `grant = 00`, `busy = 0`, `mem_select = 0`, both `data_ready = 0`, `timeout_err = 0`, both `data_out = 0`.
  - Reset mid-transaction drops `mem_select` at the next edge and issues no ready pulse.
- Request latency: a select first high in cycle t, with the FSM in IDLE, gives `mem_select` high in cycle t+1.
- Completion: the requester sees ready in the same cycle as `mem_data_ready`. `mem_select` is low for at least one cycle (GAP) after every transaction.
- Back-to-back throughput, for a memory responding k cycles after select: k+2 cycles per transaction.
- Watchdog: the abort pulse occurs in the TIMEOUT-th GRANT cycle.

## Test plan
- Single CPU read: r0 read of addr 0x10, memory returns 0x5A with ready 3 cycles after select. Required: `mem_select` high cycle t+1; r0 ready with 0x5A at t+3; `grant` 01 then 00; one GAP cycle; r1 never ready.
- Tie round-robin: both ports hold select from reset, with immediate memory response. Required: grants occur in order port 0, port 1, port 0, port 1; `mem_select` low for one cycle between each grant.
- Write forwarding: r1 writes 0xC3 to data addr 0x22 while r0 is idle. Required: `mem_write = 1`, `mem_type_data = 1`, `mem_addr = 0x22`, `mem_data_in = 0xC3` throughout GRANT; r1 ready after the memory response.
- Timeout, TIMEOUT = 4: memory never responds to r0. Required: r0 ready with 0xFF in the 4th GRANT cycle; `timeout_err` pulses once; `timeout_cnt = 1`; FSM returns to IDLE.
- Coincidence and stray ready: `mem_data_ready` arrives on the expiry cycle and returns 0x11, then a stray `mem_data_ready` pulse arrives in IDLE. Required: 0x11 is delivered with no `timeout_err`; the stray pulse produces no ready on either port.
- Reset mid-GRANT: assert `rst_n` low while r1 is granted. Required: all outputs return to their reset values at the next edge; after release, a tie is granted to port 0.

Source files
------------

// File: rtl/spell_mem_arbiter_if.sv
// Bundle of requester, memory and status signals around spell_mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spell_mem_arbiter_if;
  logic       r0_select;
  logic [7:0] r0_addr;
  logic [7:0] r0_data_in;
  logic       r0_type_data;
  logic       r0_write;
  logic       r0_data_ready;
  logic [7:0] r0_data_out;

  logic       r1_select;
  logic [7:0] r1_addr;
  logic [7:0] r1_data_in;
  logic       r1_type_data;
  logic       r1_write;
  logic       r1_data_ready;
  logic [7:0] r1_data_out;

  logic       mem_select;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_type_data;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       mem_data_ready;

  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;
  logic [7:0] timeout_cnt;

  modport slave (
    input  r0_select, r0_addr, r0_data_in, r0_type_data, r0_write,
    output r0_data_ready, r0_data_out,
    input  r1_select, r1_addr, r1_data_in, r1_type_data, r1_write,
    output r1_data_ready, r1_data_out,
    output mem_select, mem_addr, mem_data_in, mem_type_data, mem_write,
    input  mem_data_out, mem_data_ready,
    output grant, busy, timeout_err, timeout_cnt
  );

  modport master (
    output r0_select, r0_addr, r0_data_in, r0_type_data, r0_write,
    input  r0_data_ready, r0_data_out,
    output r1_select, r1_addr, r1_data_in, r1_type_data, r1_write,
    input  r1_data_ready, r1_data_out,
    input  mem_select, mem_addr, mem_data_in, mem_type_data, mem_write,
    output mem_data_out, mem_data_ready,
    input  grant, busy, timeout_err, timeout_cnt
  );
endinterface

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter sharing the spell memory port between CPU (port 0) and
// loader (port 1), with a forced idle gap and a watchdog on stuck transactions.
module spell_mem_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input logic              clk,
  input logic              rst_n,
  spell_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               r_state, w_state_next;
  logic                 r_owner, w_owner_next;
  logic                 r_last, w_last_next;
  logic [TIMEOUT_W-1:0] r_wd, w_wd_next;
  logic [7:0]           r_timeout_cnt, w_timeout_cnt_next;

  logic [1:0] w_sel;
  logic [7:0] w_addr [2];
  logic [7:0] w_din  [2];
  logic [1:0] w_type;
  logic [1:0] w_wr;
  logic [1:0] w_rdy;
  logic [7:0] w_dout [2];

  logic       w_owner_sel;
  logic       w_done;
  logic       w_expire;
  logic [7:0] w_resp_data;

  assign w_sel     = {bus.r1_select, bus.r0_select};
  assign w_addr[0] = bus.r0_addr;
  assign w_addr[1] = bus.r1_addr;
  assign w_din[0]  = bus.r0_data_in;
  assign w_din[1]  = bus.r1_data_in;
  assign w_type    = {bus.r1_type_data, bus.r0_type_data};
  assign w_wr      = {bus.r1_write, bus.r0_write};

  assign w_owner_sel = w_sel[r_owner];

  always_comb begin
    w_state_next       = r_state;
    w_owner_next       = r_owner;
    w_last_next        = r_last;
    w_wd_next          = r_wd;
    w_timeout_cnt_next = r_timeout_cnt;
    w_done             = 1'b0;
    w_expire           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_sel) begin
          w_state_next = S_GRANT;
          w_wd_next    = '0;
          w_owner_next = (&w_sel) ? ~r_last : w_sel[1];
        end
      end
      S_GRANT: begin
        if (!w_owner_sel) begin
          w_state_next = S_GAP;
        end else if (bus.mem_data_ready) begin
          // A real completion beats a watchdog expiry landing on the same cycle.
          w_done       = 1'b1;
          w_last_next  = r_owner;
          w_state_next = S_GAP;
        end else if (r_wd == WD_LAST) begin
          w_expire     = 1'b1;
          w_last_next  = r_owner;
          w_state_next = S_GAP;
          if (r_timeout_cnt != 8'hFF) begin
            w_timeout_cnt_next = r_timeout_cnt + 8'd1;
          end
        end else begin
          w_wd_next = r_wd + TIMEOUT_W'(1);
        end
      end
      S_GAP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_wd          <= '0;
      r_timeout_cnt <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_owner       <= w_owner_next;
      r_last        <= w_last_next;
      r_wd          <= w_wd_next;
      r_timeout_cnt <= w_timeout_cnt_next;
    end
  end

  // Response pulses are suppressed while reset is asserted mid-transaction.
  assign w_resp_data = w_done ? bus.mem_data_out : 8'hFF;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign w_rdy[gi]  = rst_n && (w_done || w_expire) && (r_owner == 1'(gi));
      assign w_dout[gi] = w_rdy[gi] ? w_resp_data : 8'h00;
    end
  endgenerate

  assign bus.r0_data_ready = w_rdy[0];
  assign bus.r1_data_ready = w_rdy[1];
  assign bus.r0_data_out   = w_dout[0];
  assign bus.r1_data_out   = w_dout[1];

  always_comb begin
    bus.mem_select    = 1'b0;
    bus.mem_addr      = 8'h00;
    bus.mem_data_in   = 8'h00;
    bus.mem_type_data = 1'b0;
    bus.mem_write     = 1'b0;
    bus.grant         = 2'b00;
    if (r_state == S_GRANT) begin
      bus.mem_select    = w_owner_sel;
      bus.mem_addr      = w_addr[r_owner];
      bus.mem_data_in   = w_din[r_owner];
      bus.mem_type_data = w_type[r_owner];
      bus.mem_write     = w_wr[r_owner];
      bus.grant         = r_owner ? 2'b10 : 2'b01;
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = rst_n && w_expire;
  assign bus.timeout_cnt = r_timeout_cnt;

endmodule
